// File: rtl/dpd_coef_bank_ctrl_if.sv
// Coefficient bus from the bank controller to the 3-tap x 5-order memory-polynomial DPD core.
interface intf_coef_3_5 #(
  parameter int N_COEF = 15,
  parameter int W      = 20
);
  logic signed [W-1:0] i [N_COEF];
  logic signed [W-1:0] q [N_COEF];

  modport ctrl (output i, q);
  modport core (input i, q);
endinterface

// File: rtl/dpd_coef_bank_ctrl.sv
// Double-buffered DPD coefficient bank: shadow writes, strobe-aligned atomic swap, settle, ack.
// Optional active-bank readback port enabled by defining DPD_COEF_READBACK_EN.
module dpd_coef_bank_ctrl #(
  parameter int N_COEF = 15,
  parameter int W      = 20,
  parameter int UNITY  = 2**18,
  parameter int SETTLE = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [3:0]          wr_addr,
  input  logic signed [W-1:0] wr_i,
  input  logic signed [W-1:0] wr_q,
  input  logic                commit_req,
  input  logic                sync_stb,
  output logic                commit_ack,
  output logic                busy,
  output logic                addr_err,
`ifdef DPD_COEF_READBACK_EN
  input  logic [3:0]          rd_addr,
  output logic signed [W-1:0] rd_i,
  output logic signed [W-1:0] rd_q,
`endif
  intf_coef_3_5.ctrl          coeff
);

  localparam int         CW       = $clog2(SETTLE + 1);
  localparam logic [3:0] N_COEF_A = 4'(N_COEF);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SWAP, S_SETTLE, S_ACK} state_t;

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic signed [W-1:0] shadow_i_reg [N_COEF];
  logic signed [W-1:0] shadow_q_reg [N_COEF];
  logic signed [W-1:0] active_i_reg [N_COEF];
  logic signed [W-1:0] active_q_reg [N_COEF];

  // Shadow writes are resolved at the same edge that leaves ARMED, so SWAP always sees them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      wr_ready   <= 1'b1;
      busy       <= 1'b0;
      commit_ack <= 1'b0;
      addr_err   <= 1'b0;
      for (int k = 0; k < N_COEF; k++) begin
        shadow_i_reg[k] <= (k == 0) ? W'(UNITY) : '0;
        shadow_q_reg[k] <= '0;
        active_i_reg[k] <= (k == 0) ? W'(UNITY) : '0;
        active_q_reg[k] <= '0;
      end
    end else begin
      commit_ack <= 1'b0;
      if (wr_valid && wr_ready) begin
        if (wr_addr < N_COEF_A) begin
          shadow_i_reg[wr_addr] <= wr_i;
          shadow_q_reg[wr_addr] <= wr_q;
        end else begin
          addr_err <= 1'b1;
        end
      end
      case (state_reg)
        S_IDLE: begin
          if (commit_req) begin
            busy <= 1'b1;
            if (sync_stb) begin
              state_reg <= S_SWAP;
              wr_ready  <= 1'b0;
            end else begin
              state_reg <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (sync_stb) begin
            state_reg <= S_SWAP;
            wr_ready  <= 1'b0;
          end
        end
        S_SWAP: begin
          for (int k = 0; k < N_COEF; k++) begin
            active_i_reg[k] <= shadow_i_reg[k];
            active_q_reg[k] <= shadow_q_reg[k];
          end
          cnt_reg   <= CW'(SETTLE - 1);
          state_reg <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg  <= S_ACK;
            commit_ack <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_ACK: begin
          state_reg <= S_IDLE;
          wr_ready  <= 1'b1;
          addr_err  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          wr_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N_COEF; gi++) begin : g_coeff_out
    assign coeff.i[gi] = active_i_reg[gi];
    assign coeff.q[gi] = active_q_reg[gi];
  end

`ifdef DPD_COEF_READBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_i <= '0;
      rd_q <= '0;
    end else if (rd_addr < N_COEF_A) begin
      rd_i <= active_i_reg[rd_addr];
      rd_q <= active_q_reg[rd_addr];
    end else begin
      rd_i <= '0;
      rd_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dpd_coef_bank_ctrl.sv
// Directed self-checking bench for dpd_coef_bank_ctrl (default build; readback steps when enabled).
module tb_dpd_coef_bank_ctrl;
  localparam int N_COEF = 15;
  localparam int W      = 20;
  localparam int UNITY  = 2**18;
  localparam int SETTLE = 24;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [3:0]          wr_addr = '0;
  logic signed [W-1:0] wr_i = '0;
  logic signed [W-1:0] wr_q = '0;
  logic                commit_req = 1'b0;
  logic                sync_stb = 1'b0;
  logic                commit_ack;
  logic                busy;
  logic                addr_err;
`ifdef DPD_COEF_READBACK_EN
  logic [3:0]          rd_addr = '0;
  logic signed [W-1:0] rd_i;
  logic signed [W-1:0] rd_q;
`endif

  intf_coef_3_5 #(.N_COEF(N_COEF), .W(W)) coeff_if ();

  dpd_coef_bank_ctrl #(.N_COEF(N_COEF), .W(W), .UNITY(UNITY), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_i(wr_i), .wr_q(wr_q),
    .commit_req(commit_req), .sync_stb(sync_stb),
    .commit_ack(commit_ack), .busy(busy), .addr_err(addr_err),
`ifdef DPD_COEF_READBACK_EN
    .rd_addr(rd_addr), .rd_i(rd_i), .rd_q(rd_q),
`endif
    .coeff(coeff_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int vi, input int vq);
    wr_valid = 1'b1;
    wr_addr  = 4'(addr);
    wr_i     = W'(vi);
    wr_q     = W'(vq);
    step();
    wr_valid = 1'b0;
  endtask

  // Called n cycles after the commit cycle; steps until commit_ack, checks latency and ACK-cycle state.
  task automatic wait_ack(input string tag, input int n_start);
    int n;
    n = n_start;
    while (commit_ack !== 1'b1 && n < 100) begin
      chk({tag, "_wr_ready_low"}, 32'(wr_ready), 0);
      step();
      n++;
    end
    chk({tag, "_ack_latency"}, n, SETTLE + 2);
    chk({tag, "_ack_wr_ready"}, 32'(wr_ready), 0);
    chk({tag, "_ack_busy"}, 32'(busy), 0);
    step();
    chk({tag, "_ack_one_cycle"}, 32'(commit_ack), 0);
    chk({tag, "_idle_wr_ready"}, 32'(wr_ready), 1);
  endtask

  initial begin
    int ack_seen;

    // Reset state
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_i0", coeff_if.i[0], UNITY);
    for (int k = 1; k < N_COEF; k++) chk($sformatf("rst_i%0d", k), coeff_if.i[k], 0);
    for (int k = 0; k < N_COEF; k++) chk($sformatf("rst_q%0d", k), coeff_if.q[k], 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(commit_ack), 0);
    chk("rst_addr_err", 32'(addr_err), 0);

    // Load i=k*100, q=-k, then commit with coincident strobe
    for (int k = 0; k < N_COEF; k++) wr(k, k * 100, -k);
    chk("t2_pre_i0", coeff_if.i[0], UNITY);
    commit_req = 1'b1;
    sync_stb   = 1'b1;
    step();
    commit_req = 1'b0;
    sync_stb   = 1'b0;
    chk("t2_swap_wr_ready", 32'(wr_ready), 0);
    chk("t2_swap_busy", 32'(busy), 1);
    chk("t2_swap_i1_old", coeff_if.i[1], 0);
    step();
    for (int k = 0; k < N_COEF; k++) begin
      chk($sformatf("t2_i%0d", k), coeff_if.i[k], k * 100);
      chk($sformatf("t2_q%0d", k), coeff_if.q[k], -k);
    end
    wait_ack("t2", 2);

`ifdef DPD_COEF_READBACK_EN
    rd_addr = 4'd2;
    step();
    chk("t6_rd_i2", rd_i, 200);
    chk("t6_rd_q2", rd_q, -2);
    rd_addr = 4'd15;
    step();
    chk("t6_rd_i15", rd_i, 0);
    chk("t6_rd_q15", rd_q, 0);
`endif

    // Commit armed, strobe 10 cycles later; write to addr 3 while armed
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    chk("t3_armed_busy", 32'(busy), 1);
    chk("t3_armed_wr_ready", 32'(wr_ready), 1);
    for (int j = 1; j < 10; j++) begin
      if (j == 4) begin
        wr(3, 777, -7);
      end else begin
        step();
      end
      chk($sformatf("t3_hold_i3_c%0d", j), coeff_if.i[3], 300);
    end
    sync_stb = 1'b1;
    step();
    sync_stb = 1'b0;
    chk("t3_swap_i3_old", coeff_if.i[3], 300);
    step();
    chk("t3_i3", coeff_if.i[3], 777);
    chk("t3_q3", coeff_if.q[3], -7);
    chk("t3_i4", coeff_if.i[4], 400);
    wait_ack("t3", 2);

    // Out-of-range write: flag set, banks untouched, flag cleared after next ack
    wr(15, 32'h7FFFF, 32'h7FFFF);
    chk("t4_addr_err_set", 32'(addr_err), 1);
    chk("t4_active_i0", coeff_if.i[0], 0);
    commit_req = 1'b1;
    sync_stb   = 1'b1;
    step();
    commit_req = 1'b0;
    sync_stb   = 1'b0;
    step();
    for (int k = 0; k < N_COEF; k++) begin
      chk($sformatf("t4_i%0d", k), coeff_if.i[k], (k == 3) ? 777 : k * 100);
      chk($sformatf("t4_q%0d", k), coeff_if.q[k], (k == 3) ? -7 : -k);
    end
    chk("t4_addr_err_held", 32'(addr_err), 1);
    wait_ack("t4", 2);
    chk("t4_addr_err_clr", 32'(addr_err), 0);

    // Reset during SETTLE: identity at once, no ack afterwards
    commit_req = 1'b1;
    sync_stb   = 1'b1;
    step();
    commit_req = 1'b0;
    sync_stb   = 1'b0;
    repeat (5) step();
    chk("t5_pre_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_i0", coeff_if.i[0], UNITY);
    chk("t5_rst_i3", coeff_if.i[3], 0);
    chk("t5_rst_q3", coeff_if.q[3], 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_wr_ready", 32'(wr_ready), 1);
    step();
    reset_n  = 1'b1;
    ack_seen = 0;
    for (int j = 0; j < SETTLE + 16; j++) begin
      step();
      if (commit_ack === 1'b1) ack_seen = 1;
    end
    chk("t5_no_ack", ack_seen, 0);
    chk("t5_i0_hold", coeff_if.i[0], UNITY);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
